out_ram_arbiter: RTL and testbench
==================================

// Module: out_ram_arbiter
// PURPOSE
//  Shares one simple-dual-port output RAM among the 4 switch output ports. Round-robin arbitrates
//  one word/cycle into per-port circular regions; serves host pops and status reads over the
//  chipselect/read/address bus. Sits between switch fabric outputs and the HPS-facing register bus.
// PARAMETERS
//  DW       32  data word width
//  RGN_AW   10  per-port region address width; region depth DEPTH = 2**RGN_AW words
// PORTS
//  clk             in   1            system clock
//  reset           in   1            synchronous, active-high reset
//  clear           in   1            sync soft clear: pointers/levels/FSM, like reset
//  req_valid[4]    in   1 each       port i has a word
//  req_data[4]     in   DW each      port i word
//  req_ready[4]    out  1 each       port i granted this cycle (comb); transfer = valid&&ready
//  ram_wren        out  1            RAM write strobe (comb, = any transfer)
//  ram_wraddress   out  RGN_AW+2     {port, wr_ptr[port]}
//  ram_data        out  DW           granted port's req_data
//  ram_rden        out  1            RAM read strobe (registered)
//  ram_rdaddress   out  RGN_AW+2     {port, rd_ptr[port]} (registered)
//  ram_q           in   DW           RAM read data, valid 1 cycle after ram_rden
//  chipselect,read in   1            host read strobe
//  address         in   4            host word address
//  readdata        out  DW           host data (registered)
//  readdata_valid  out  1            1-cycle pulse: readdata updated
// BEHAVIOUR
//  Reset/clear: wr_ptr=rd_ptr=level=0 for all ports, rr_ptr=0, FSM=IDLE, ram_rden=0,
//   readdata=0, readdata_valid=0. Comb outputs follow (req_ready=0 until valid seen).
//  Arbitration: eligible[i]=req_valid[i] && level[i]!=DEPTH. Grant first eligible from rr_ptr
//   upward mod 4; at most one grant/cycle. On transfer: wr_ptr[g]++ (wraps mod DEPTH),
//   level[g]++, rr_ptr<=g+1 mod 4. No transfer -> rr_ptr holds. Full port never granted.
//  Host read FSM IDLE->FETCH->CAPT->IDLE:
//   IDLE, cs&&read, address 0-3 (pop port a): level[a]!=0 -> ram_rden<=1, ram_rdaddress<={a,rd_ptr[a]},
//    go FETCH. level[a]==0 -> readdata<=0, readdata_valid<=1, stay IDLE.
//   FETCH: ram_rden<=0 -> CAPT. CAPT: readdata<=ram_q, readdata_valid<=1, rd_ptr[a]++ (wraps),
//    level[a]--, -> IDLE. Pop latency 3 cycles strobe->readdata_valid.
//   IDLE, cs&&read, address 4-7: readdata<=level[address-4] (zero-extended), valid next cycle.
//   address 8: readdata<={24'b0, full[3:0], empty[3:0]}. address 9: {30'b0, rr_ptr}.
//   address 12-15: see CONFIGURATION. Other addresses: readdata<=32'h000000FF.
//   Strobes outside IDLE ignored (no response); host must wait for readdata_valid.
//  Simultaneous transfer and CAPT-pop on same port: level unchanged, both pointers advance.
//  Pop only reads committed words (write comb, level updated same edge) -> no RAW hazard;
//   full region: wr_ptr==rd_ptr and level==DEPTH (level disambiguates full/empty).
//  clear/reset mid-pop: pop aborted, no readdata_valid, level/pointers zeroed; clear wins over
//   same-cycle transfer/pop (transfer still drives ram_wren but is discarded).
//  level width RGN_AW+1; never exceeds DEPTH nor underflows.
// CONFIGURATION
//  OUT_RAM_ARB_DROPCNT_EN defined: per-port 16-bit saturating counter drop_cnt[i], +1 each cycle
//   req_valid[i] && level[i]==DEPTH; holds at 16'hFFFF; zeroed by reset/clear; address 12+i
//   returns {16'b0, drop_cnt[i]}.
//  Not defined: no counters; address 12-15 returns 32'h0.
// TESTING
//  1 all 4 ports valid continuously, all empty -> grants 0,1,2,3,0,... one/cycle; each level
//    increments by 1 per 4 cycles; ram_wraddress {i,ptr} correct.
//  2 port 2 writes 0xA0..0xA4, then pops at address 2 x5 -> readdata 0xA0..0xA4 in order,
//    each 3 cycles after strobe; 6th pop -> readdata 0, level[2]=0, address 8 empty bit2=1.
//  3 RGN_AW=2: port 1 writes 6 words -> 4 accepted, req_ready[1]=0 after; address 8 full bit1=1;
//    with DROPCNT_EN address 13 reads 2 (2 full-valid cycles), without reads 0.
//  4 port 0 streaming while popping port 0 at DEPTH-1 -> level constant at CAPT edge, wr_ptr and
//    rd_ptr wrap 3->0 without data loss (sequence check over 3*DEPTH words).
//  5 clear asserted in FETCH -> no readdata_valid, levels all 0, next write lands at {i,0}.
//  6 address 5 read -> readdata=level[1] next cycle; address 10 -> 32'h000000FF.

Source files
------------

// File: rtl/out_ram_arbiter.sv
// Round-robin writer of 4 switch output ports into per-port circular regions of one output RAM,
// with a host pop/status read FSM. Define OUT_RAM_ARB_DROPCNT_EN for per-port drop counters.
module out_ram_arbiter #(
   parameter int unsigned DW     = 32,
   parameter int unsigned RGN_AW = 10
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_clear,
   input  logic [3:0]        i_req_valid,
   input  logic [4*DW-1:0]   i_req_data,
   output logic [3:0]        o_req_ready,
   output logic              o_ram_wren,
   output logic [RGN_AW+1:0] o_ram_wraddress,
   output logic [DW-1:0]     o_ram_data,
   output logic              o_ram_rden,
   output logic [RGN_AW+1:0] o_ram_rdaddress,
   input  logic [DW-1:0]     i_ram_q,
   input  logic              i_chipselect,
   input  logic              i_read,
   input  logic [3:0]        i_address,
   output logic [DW-1:0]     o_readdata,
   output logic              o_readdata_valid
);

   localparam int unsigned DEPTH = 2**RGN_AW;
   localparam int unsigned LW    = RGN_AW + 1;

   typedef enum logic [1:0] {StIdle, StFetch, StCapt} state_t;

   logic [RGN_AW-1:0] r_wr_ptr [4];
   logic [RGN_AW-1:0] r_rd_ptr [4];
   logic [LW-1:0]     r_level  [4];
   logic [1:0]        r_rr_ptr;
   logic [1:0]        r_port;
   state_t            r_state;
   logic              r_ram_rden;
   logic [RGN_AW+1:0] r_ram_rdaddress;
   logic [DW-1:0]     r_readdata;
   logic              r_readdata_valid;
`ifdef OUT_RAM_ARB_DROPCNT_EN
   logic [15:0]       r_drop_cnt [4];
`endif

   logic [3:0]        w_elig;
   logic [3:0]        w_full;
   logic [3:0]        w_empty;
   logic [3:0]        w_inc;
   logic [3:0]        w_dec;
   logic              w_gnt_any;
   logic [1:0]        w_gnt_idx;
   logic [1:0]        w_a;
   logic [DW-1:0]     w_req_data [4];

   assign w_a = i_address[1:0];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_req_data[i] = i_req_data[i*DW +: DW];
         w_full[i]     = (r_level[i] == LW'(DEPTH));
         w_empty[i]    = (r_level[i] == '0);
         w_elig[i]     = i_req_valid[i] && !w_full[i];
      end
   end

   // First eligible port searching upward from r_rr_ptr, wrapping mod 4.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = r_rr_ptr;
      for (int k = 0; k < 4; k++) begin
         if (!w_gnt_any && w_elig[2'(r_rr_ptr + 2'(k))]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = 2'(r_rr_ptr + 2'(k));
         end
      end
      w_inc            = '0;
      w_inc[w_gnt_idx] = w_gnt_any;
      w_dec            = '0;
      w_dec[r_port]    = (r_state == StCapt);
   end

   assign o_req_ready      = w_inc;
   assign o_ram_wren       = w_gnt_any;
   assign o_ram_wraddress  = {w_gnt_idx, r_wr_ptr[w_gnt_idx]};
   assign o_ram_data       = w_req_data[w_gnt_idx];
   assign o_ram_rden       = r_ram_rden;
   assign o_ram_rdaddress  = r_ram_rdaddress;
   assign o_readdata       = r_readdata;
   assign o_readdata_valid = r_readdata_valid;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         for (int i = 0; i < 4; i++) begin
            r_wr_ptr[i] <= '0;
            r_rd_ptr[i] <= '0;
            r_level[i]  <= '0;
`ifdef OUT_RAM_ARB_DROPCNT_EN
            r_drop_cnt[i] <= '0;
`endif
         end
         r_rr_ptr         <= '0;
         r_port           <= '0;
         r_state          <= StIdle;
         r_ram_rden       <= 1'b0;
         r_ram_rdaddress  <= '0;
         r_readdata       <= '0;
         r_readdata_valid <= 1'b0;
      end else begin
         r_readdata_valid <= 1'b0;
         if (w_gnt_any) begin
            r_wr_ptr[w_gnt_idx] <= r_wr_ptr[w_gnt_idx] + RGN_AW'(1);
            r_rr_ptr            <= w_gnt_idx + 2'd1;
         end
         // A same-edge write and pop on one port cancel out in the level.
         for (int i = 0; i < 4; i++) begin
            r_level[i] <= r_level[i] + LW'(w_inc[i]) - LW'(w_dec[i]);
`ifdef OUT_RAM_ARB_DROPCNT_EN
            if (i_req_valid[i] && w_full[i] && r_drop_cnt[i] != 16'hFFFF) begin
               r_drop_cnt[i] <= r_drop_cnt[i] + 16'd1;
            end
`endif
         end
         case (r_state)
            StIdle: begin
               if (i_chipselect && i_read) begin
                  case (i_address)
                     4'd0, 4'd1, 4'd2, 4'd3: begin
                        r_port <= w_a;
                        if (!w_empty[w_a]) begin
                           r_ram_rden      <= 1'b1;
                           r_ram_rdaddress <= {w_a, r_rd_ptr[w_a]};
                           r_state         <= StFetch;
                        end else begin
                           r_readdata       <= '0;
                           r_readdata_valid <= 1'b1;
                        end
                     end
                     4'd4, 4'd5, 4'd6, 4'd7: begin
                        r_readdata       <= DW'(r_level[w_a]);
                        r_readdata_valid <= 1'b1;
                     end
                     4'd8: begin
                        r_readdata       <= DW'({w_full, w_empty});
                        r_readdata_valid <= 1'b1;
                     end
                     4'd9: begin
                        r_readdata       <= DW'(r_rr_ptr);
                        r_readdata_valid <= 1'b1;
                     end
                     4'd12, 4'd13, 4'd14, 4'd15: begin
`ifdef OUT_RAM_ARB_DROPCNT_EN
                        r_readdata       <= DW'(r_drop_cnt[w_a]);
`else
                        r_readdata       <= '0;
`endif
                        r_readdata_valid <= 1'b1;
                     end
                     default: begin
                        r_readdata       <= DW'(32'h0000_00FF);
                        r_readdata_valid <= 1'b1;
                     end
                  endcase
               end
            end
            StFetch: begin
               r_ram_rden <= 1'b0;
               r_state    <= StCapt;
            end
            StCapt: begin
               r_readdata         <= i_ram_q;
               r_readdata_valid   <= 1'b1;
               r_rd_ptr[r_port]   <= r_rd_ptr[r_port] + RGN_AW'(1);
               r_state            <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_out_ram_arbiter.sv
// Directed self-checking bench for out_ram_arbiter with a 4-word region per port.
module tb_out_ram_arbiter;

   localparam int DW     = 32;
   localparam int RGN_AW = 2;

   logic              clk = 1'b0;
   logic              reset, clear;
   logic [3:0]        req_valid;
   logic [4*DW-1:0]   req_data;
   logic [3:0]        req_ready;
   logic              ram_wren, ram_rden;
   logic [RGN_AW+1:0] ram_wraddress, ram_rdaddress;
   logic [DW-1:0]     ram_data, ram_q, readdata;
   logic              chipselect, rd;
   logic [3:0]        address;
   logic              readdata_valid;
   logic [DW-1:0]     mem [16];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   out_ram_arbiter #(.DW(DW), .RGN_AW(RGN_AW)) dut (
      .i_clk(clk), .i_reset(reset), .i_clear(clear),
      .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
      .o_ram_wren(ram_wren), .o_ram_wraddress(ram_wraddress), .o_ram_data(ram_data),
      .o_ram_rden(ram_rden), .o_ram_rdaddress(ram_rdaddress), .i_ram_q(ram_q),
      .i_chipselect(chipselect), .i_read(rd), .i_address(address),
      .o_readdata(readdata), .o_readdata_valid(readdata_valid)
   );

   // Simple-dual-port RAM with one cycle read latency.
   always @(posedge clk) begin
      if (ram_wren) mem[ram_wraddress] <= ram_data;
      if (ram_rden) ram_q <= mem[ram_rdaddress];
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic v, input logic [31:0] d);
      req_valid[p]         = v;
      req_data[p*DW +: DW] = d;
   endtask

   task automatic host_read(input logic [3:0] a, output logic [31:0] data, output int lat);
      chipselect = 1'b1;
      rd         = 1'b1;
      address    = a;
      tick();
      chipselect = 1'b0;
      rd         = 1'b0;
      lat        = 1;
      while (!readdata_valid && lat < 10) begin
         tick();
         lat++;
      end
      data = readdata;
   endtask

   task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp,
                           input int exp_lat);
      logic [31:0] d;
      int          l;
      host_read(a, d, l);
      check_eq(tag, d, exp);
      check_eq({tag, "_lat"}, l, exp_lat);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      int          l;
      int          nxt;
      logic        acc;
      logic        seen;
      int          wseq;
      int          rseq;

      reset = 1'b1; clear = 1'b0; req_valid = '0; req_data = '0;
      chipselect = 1'b0; rd = 1'b0; address = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check_eq("rst_readdata", readdata, 32'h0);
      check_eq("rst_rdvalid", readdata_valid, 0);
      check_eq("rst_rden", ram_rden, 0);
      check_eq("rst_wren", ram_wren, 0);
      check_eq("rst_ready", req_ready, 0);
      read_chk("rst_status", 4'd8, 32'h0F, 1);
      read_chk("rst_rrptr", 4'd9, 32'h0, 1);

      // All ports valid: grants rotate 0..3 with per-port pointers advancing every 4 cycles.
      for (int c = 0; c < 8; c++) begin
         for (int p = 0; p < 4; p++) set_port(p, 1'b1, 32'h100 * p + c);
         #1;
         check_eq("t1_ready", req_ready, 32'(4'b0001 << (c % 4)));
         check_eq("t1_wraddr", ram_wraddress, ((c % 4) << 2) | (c / 4));
         check_eq("t1_wdata", ram_data, 32'h100 * (c % 4) + c);
         check_eq("t1_wren", ram_wren, 1);
         tick();
      end
      req_valid = '0;
      for (int p = 0; p < 4; p++) read_chk("t1_level", 4'(4 + p), 32'd2, 1);
      read_chk("t1_status", 4'd8, 32'h00, 1);
      read_chk("t1_pop3", 4'd3, 32'h303, 3);
      pulse_clear();

      // Port 2 fills its region, then pops drain it in order; one more pop returns 0.
      for (int k = 0; k < 4; k++) begin
         set_port(2, 1'b1, 32'hA0 + k);
         #1;
         check_eq("t2_ready", req_ready, 32'b0100);
         tick();
      end
      set_port(2, 1'b0, 32'h0);
      for (int k = 0; k < 4; k++) read_chk("t2_pop", 4'd2, 32'hA0 + k, 3);
      tick();
      check_eq("t2_vpulse", readdata_valid, 0);
      read_chk("t2_pop_empty", 4'd2, 32'h0, 1);
      read_chk("t2_level", 4'd6, 32'h0, 1);
      read_chk("t2_status", 4'd8, 32'h0F, 1);

      // Port 1 offers 6 words into a 4-deep region; the last two cycles are refused.
      nxt = 0;
      for (int c = 0; c < 6; c++) begin
         set_port(1, 1'b1, 32'hB0 + nxt);
         #1;
         check_eq("t3_ready", req_ready[1], (c < 4) ? 1 : 0);
         acc = req_ready[1];
         tick();
         if (acc) nxt++;
      end
      set_port(1, 1'b0, 32'h0);
      read_chk("t3_status", 4'd8, 32'h2D, 1);
`ifdef OUT_RAM_ARB_DROPCNT_EN
      read_chk("t3_drop", 4'd13, 32'd2, 1);
`else
      read_chk("t3_drop", 4'd13, 32'd0, 1);
`endif
      read_chk("t6_level1", 4'd5, 32'd4, 1);
      read_chk("t6_bad_addr10", 4'd10, 32'hFF, 1);
      read_chk("t6_bad_addr11", 4'd11, 32'hFF, 1);
      read_chk("t3_rrptr", 4'd9, 32'd2, 1);
      for (int k = 0; k < 4; k++) read_chk("t3_pop", 4'd1, 32'hB0 + k, 3);
      read_chk("t3_level_after", 4'd5, 32'd0, 1);
      pulse_clear();

      // Port 0 held at 3 words; every pop coincides with a write on the CAPT edge.
      for (int k = 0; k < 3; k++) begin
         set_port(0, 1'b1, 32'h400 + k);
         #1;
         check_eq("t4_pre_ready", req_ready, 32'b0001);
         tick();
      end
      set_port(0, 1'b0, 32'h0);
      wseq = 3;
      rseq = 0;
      for (int it = 0; it < 12; it++) begin
         chipselect = 1'b1; rd = 1'b1; address = 4'd0;
         tick();
         chipselect = 1'b0; rd = 1'b0;
         tick();
         set_port(0, 1'b1, 32'h400 + wseq);
         #1;
         check_eq("t4_ready", req_ready, 32'b0001);
         check_eq("t4_wraddr", ram_wraddress, wseq % 4);
         tick();
         set_port(0, 1'b0, 32'h0);
         wseq++;
         check_eq("t4_rdvalid", readdata_valid, 1);
         check_eq("t4_data", readdata, 32'h400 + rseq);
         rseq++;
         read_chk("t4_level", 4'd4, 32'd3, 1);
      end
      for (int k = 0; k < 3; k++) begin
         read_chk("t4_drain", 4'd0, 32'h400 + rseq, 3);
         rseq++;
      end
      pulse_clear();

      // Clear during FETCH aborts the pop and zeroes everything.
      for (int k = 0; k < 2; k++) begin
         set_port(3, 1'b1, 32'hC0 + k);
         tick();
      end
      set_port(3, 1'b0, 32'h0);
      chipselect = 1'b1; rd = 1'b1; address = 4'd3;
      tick();
      chipselect = 1'b0; rd = 1'b0;
      check_eq("t5_rden", ram_rden, 1);
      check_eq("t5_rdaddr", ram_rdaddress, 4'b1100);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_eq("t5_rden_clr", ram_rden, 0);
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (readdata_valid) seen = 1'b1;
         tick();
      end
      check_eq("t5_no_valid", seen, 0);
      for (int p = 0; p < 4; p++) read_chk("t5_level", 4'(4 + p), 32'd0, 1);
      set_port(2, 1'b1, 32'hD2);
      set_port(3, 1'b1, 32'hD3);
      #1;
      check_eq("t5_wraddr_p2", ram_wraddress, 4'b1000);
      tick();
      check_eq("t5_wraddr_p3", ram_wraddress, 4'b1100);
      check_eq("t5_wdata_p3", ram_data, 32'hD3);
      tick();
      req_valid = '0;
      read_chk("t5_pop3", 4'd3, 32'hD3, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
